// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: address width, reset vector, NOP encoding
// and the instruction-fetch FSM state type.
package mips_pkg;

    localparam int              ADDR_W   = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0]     NOP_INST = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction skid buffer: parks a word returned by memory while the
// pipeline is stalled, and releases it when the stall lifts.
module if_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic [31:0] load_data,
    output logic        valid,
    output logic [31:0] data
);
    import mips_pkg::*;

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the single data register is reset along with the valid flag so the
    // buffer reads as a clean NOP after reset; a deeper array would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, memory request FSM, delay-slot redirects
// and the IF/ID register. Build option IF_ADEL_EN adds misaligned-PC traps.
module if_fetch_stage #(
    parameter int                ADDR_W   = mips_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_stall,
    input  logic              ID_stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_rdy,
    input  logic [31:0]       inst_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_inst
`ifdef IF_ADEL_EN
    ,
    output logic              id_adel
`endif
);
    import mips_pkg::*;

    if_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_pend_q, redirect_pend_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]       id_inst_q, id_inst_d;

    logic              stall, redir_acc, use_redirect, misaligned;
    logic              deliver_mem, deliver_buf, deliver_adel, capture;
    logic [ADDR_W-1:0] redir_tgt, redirect_pc, next_pc;
    logic              buf_valid;
    logic [31:0]       buf_data;

`ifdef IF_ADEL_EN
    logic adel_sent_q, adel_sent_d;
    logic id_adel_q, id_adel_d;
    assign redir_tgt    = redirect_target;
    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign deliver_adel = (state_q == FETCH) && misaligned && !adel_sent_q && !stall;
`else
    assign redir_tgt    = redirect_target & ~ADDR_W'(3);
    assign misaligned   = 1'b0;
    assign deliver_adel = 1'b0;
`endif

    // An IF-only release with ID still held is treated as a full stall.
    assign stall        = IF_stall | ID_stall;
    assign redir_acc    = redirect_valid && !ID_stall;
    assign use_redirect = redirect_pend_q || redir_acc;
    assign redirect_pc  = redirect_pend_q ? pend_target_q : redir_tgt;
    assign next_pc      = use_redirect ? redirect_pc : pc_q + ADDR_W'(4);

    assign deliver_mem  = (state_q == FETCH) && !misaligned && inst_rdy && !stall;
    assign capture      = (state_q == FETCH) && !misaligned && inst_rdy && stall;
    assign deliver_buf  = (state_q == HOLD) && buf_valid && !stall;

    if_hold_buf u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .unload    (deliver_buf),
        .load_data (inst_rdata),
        .valid     (buf_valid),
        .data      (buf_data)
    );

    // NOTE: every variable gets its hold value first, so paths that do not
    // assign it cannot infer a latch.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_pend_d = redirect_pend_q;
        pend_target_d   = pend_target_q;
        id_valid_d      = id_valid_q;
        id_pc_d         = id_pc_q;
        id_inst_d       = id_inst_q;
`ifdef IF_ADEL_EN
        adel_sent_d     = adel_sent_q;
        id_adel_d       = id_adel_q;
`endif
        if (deliver_mem || deliver_buf || deliver_adel) begin
            id_valid_d      = 1'b1;
            id_pc_d         = pc_q;
            id_inst_d       = deliver_buf ? buf_data : (deliver_mem ? inst_rdata : NOP_INST);
            pc_d            = (deliver_adel && !use_redirect) ? pc_q : next_pc;
            redirect_pend_d = 1'b0;
            state_d         = FETCH;
`ifdef IF_ADEL_EN
            id_adel_d       = deliver_adel;
            adel_sent_d     = deliver_adel && !use_redirect;
`endif
        end else begin
            if (capture) begin
                state_d = HOLD;
            end
            if (redir_acc) begin
                redirect_pend_d = 1'b1;
                pend_target_d   = redir_tgt;
            end
            if (!ID_stall) begin
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
`ifdef IF_ADEL_EN
                id_adel_d  = 1'b0;
`endif
            end
`ifdef IF_ADEL_EN
            // A trapped PC stays parked until a redirect moves it elsewhere.
            if (adel_sent_q && use_redirect && !stall) begin
                pc_d            = redirect_pc;
                redirect_pend_d = 1'b0;
                adel_sent_d     = 1'b0;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FETCH;
            pc_q            <= RESET_PC;
            redirect_pend_q <= 1'b0;
            pend_target_q   <= '0;
            id_valid_q      <= 1'b0;
            id_pc_q         <= '0;
            id_inst_q       <= NOP_INST;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_pend_q <= redirect_pend_d;
            pend_target_q   <= pend_target_d;
            id_valid_q      <= id_valid_d;
            id_pc_q         <= id_pc_d;
            id_inst_q       <= id_inst_d;
        end
    end

`ifdef IF_ADEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adel_sent_q <= 1'b0;
            id_adel_q   <= 1'b0;
        end else begin
            adel_sent_q <= adel_sent_d;
            id_adel_q   <= id_adel_d;
        end
    end
    assign id_adel = id_adel_q;
`endif

    assign inst_req  = !rst && (state_q == FETCH) && !misaligned;
    assign inst_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;

    // A branch cannot sit in ID while its own delay-slot redirect is pending.
    a_no_redirect_while_pend: assert property (@(posedge clk) disable iff (rst)
        !(redirect_valid && !ID_stall && redirect_pend_q));

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC and the instruction-memory request, and drives the IF/ID pipeline register consumed by decode and the hazard unit.
- Honours IF_stall/ID_stall from the hazard unit.
- Applies branch/jump redirects resolved in ID, with MIPS delay-slot semantics.
- Buffers one returned instruction when the pipeline stalls mid-fetch.

Parameters:
RESET_PC, 32'h80000000, first fetch address after reset
ADDR_W, 32, PC / instruction address width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
IF_stall  in  1  hazard: do not advance PC / accept new instruction
ID_stall  in  1  hazard: hold IF/ID register contents
redirect_valid  in  1  ID resolved taken branch/jump (sampled only when ID_stall=0)
redirect_target  in  ADDR_W  target of that branch/jump
inst_req  out  1  fetch request to instruction memory arbiter
inst_addr  out  ADDR_W  fetch address, word aligned
inst_rdy  in  1  memory returns data this cycle
inst_rdata  in  32  instruction word
id_valid  out  1  IF/ID register holds a real instruction
id_pc  out  ADDR_W  PC of IF/ID instruction
id_inst  out  32  IF/ID instruction (32'h0 = NOP when invalid)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: pc_q=RESET_PC, state=FETCH, inst_req=0 during reset, id_valid=0, id_pc=0, id_inst=0, redirect_pend=0, hold buffer empty.
- States:
  - FETCH: inst_req=1, inst_addr=pc_q. Address is stable until inst_rdy.
  - HOLD: inst_req=0. Returned word is parked in the hold buffer.
- Memory handshake:
  - Once raised, req stays high with a constant address until inst_rdy=1.
  - rdy may arrive in the same cycle as req or any later cycle.
  - Arbitration against data accesses is external; IF_stall never drops req.
- Delivery: an instruction is delivered when (FETCH & inst_rdy & !IF_stall) or (HOLD & !IF_stall). On delivery:
  - id_valid<=1, id_pc<=pc_q, id_inst<=rdata or buffer.
  - pc_q<=next_pc.
  - state<=FETCH, so a new request is issued the next cycle.
- Minimum fetch latency: pc_q to id_valid is 1 cycle when rdy returns in the same cycle, giving 1 instruction/cycle throughput.
- FETCH & inst_rdy & IF_stall: capture rdata into the hold buffer, state<=HOLD, pc_q unchanged.
- No delivery, ID_stall=0: id_valid<=0, id_inst<=0 (bubble).
- No delivery, ID_stall=1: IF/ID holds.
- next_pc = (redirect_pend | (redirect_valid & !ID_stall)) ? redirect_target-derived value : pc_q+4. The add wraps modulo 2^32.
- Delay slot: when redirect_valid is accepted, the instruction at pc_q is the branch's delay slot and is always delivered.
  - If the delay slot is delivered in the same cycle: next_pc=redirect_target, and no pending redirect is recorded.
  - Otherwise: redirect_pend<=1 and redirect target is latched into pend_target.
  - The pending redirect is applied and cleared on the delay slot's delivery.
- redirect_valid while redirect_pend=1 is illegal (cannot occur in-order); assertion required.
- IF_stall and ID_stall are both 1 from the hazard unit in practice. If IF_stall=0 and ID_stall=1, delivery is suppressed (treated as stall).
- Reset mid-transaction: outstanding fetch is abandoned; the memory arbiter is reset by the same rst.

Optional Feature:
- Macro: IF_ADEL_EN.
- Defined:
  - Adds output id_adel (1 bit).
  - If pc_q[1:0]!=0 in FETCH: no request is issued.
  - Next non-stalled cycle delivers id_valid=1, id_inst=0, id_adel=1, id_pc=pc_q.
  - pc_q then holds until a redirect.
- Undefined:
  - No port.
  - redirect_target[1:0] is forced to 0 (misaligned targets are silently aligned).

Decomposition:
- Shared package mips_pkg: RESET_PC default, NOP_INST=32'h0, if_state_t enum {FETCH, HOLD}, ADDR_W.
- One natural sub-module: if_hold_buf (one-entry instruction skid buffer with valid flag, load/unload).

Test Plan:
1. Reset release, rdy every cycle, no stalls -> inst_addr 80000000, 80000004, 80000008 on consecutive cycles; id_valid=1 from cycle 2 with matching id_pc.
2. rdy delayed 3 cycles -> inst_addr held constant 3 cycles; id_valid=0 bubbles; pc_q advances only after rdy.
3. rdy together with IF_stall=ID_stall=1 for 2 cycles -> inst_req=0, IF/ID held; on stall release the buffered word appears in id_inst, then the next request goes to pc+4.
4. redirect_valid target 80001000 while the delay slot (80000008) is delivered the same cycle -> next inst_addr 80001000.
5. redirect_valid while the delay-slot fetch is waiting on rdy -> delay slot 80000008 delivered, then fetch 80001000; redirect_pend clears.
6. rst asserted mid-fetch (req high, no rdy) -> outputs clear asynchronously; first post-reset addr 80000000. Optionally, with IF_ADEL_EN, redirect to 80000002 -> id_adel=1, no inst_req.
